// File: rtl/ddr3_sim_pkg.sv
// Shared types and constants for the DDR3 Avalon-MM memory model.
// The command struct uses upper-bound widths so one type serves any ADDR_W/SIZE_W.
package ddr3_sim_pkg;

    localparam int unsigned DEF_DATA_W       = 128;
    localparam int unsigned DEF_ADDR_W       = 26;
    localparam int unsigned DEF_SIZE_W       = 3;
    localparam int unsigned DEF_MEM_AW       = 10;
    localparam int unsigned DEF_READ_LATENCY = 4;
    localparam int unsigned DEF_CMD_DEPTH    = 4;
    localparam logic [15:0] DEF_LFSR_SEED    = 16'hACE1;

    // Upper bounds on ADDR_W and SIZE_W carried through the command queue.
    localparam int unsigned CMD_ADDR_W = 32;
    localparam int unsigned CMD_SIZE_W = 8;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_SIZE_W-1:0] size;
    } rd_cmd_t;

    typedef enum logic [0:0] {WrIdle, WrBurst} wr_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/ddr3_sim_cmd_fifo.sv
// Synchronous show-ahead FIFO of read commands with full/empty flags.
module ddr3_sim_cmd_fifo
    import ddr3_sim_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_CMD_DEPTH
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  rd_cmd_t push_cmd,
    input  logic    pop,
    output rd_cmd_t pop_cmd,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    rd_cmd_t     slots [DEPTH];
    logic [PW:0] wr_ptr_q;
    logic [PW:0] rd_ptr_q;

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop_cmd = slots[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push && !full) begin
            slots[wr_ptr_q[PW-1:0]] <= push_cmd;
        end
    end

endmodule

// File: rtl/ddr3_avl_mem_model.sv
// Cycle-accurate Avalon-MM local-interface model of the DDR3 controller with
// burst writes, queued fixed-latency burst reads, preload port and error counter.
module ddr3_avl_mem_model
    import ddr3_sim_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned SIZE_W       = DEF_SIZE_W,
    parameter int unsigned MEM_AW       = DEF_MEM_AW,
    parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
    parameter int unsigned CMD_DEPTH    = DEF_CMD_DEPTH,
    parameter bit          STALL_EN     = 1'b0,
    parameter logic [15:0] LFSR_SEED    = DEF_LFSR_SEED
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                avl_ready,
    input  logic                avl_burstbegin,
    input  logic [ADDR_W-1:0]   avl_addr,
    input  logic [SIZE_W-1:0]   avl_size,
    input  logic                avl_read_req,
    input  logic                avl_write_req,
    input  logic [DATA_W-1:0]   avl_wdata,
    input  logic [DATA_W/8-1:0] avl_be,
    output logic                avl_rdata_valid,
    output logic [DATA_W-1:0]   avl_rdata,
    input  logic                dbg_wr_en,
    input  logic [MEM_AW-1:0]   dbg_addr,
    input  logic [DATA_W-1:0]   dbg_wdata,
    output logic [7:0]          err_count
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned WORDS = 2 ** MEM_AW;

    typedef logic [MEM_AW-1:0] idx_t;

    logic [DATA_W-1:0] mem [WORDS];

    logic [15:0]         lfsr_q;
    logic [7:0]          err_q;
    wr_state_e           wr_state_q;
    idx_t                wr_base_q;
    logic [SIZE_W-1:0]   wr_size_q;
    logic [SIZE_W-1:0]   wr_beat_q;
    idx_t                eng_addr_q;
    logic [SIZE_W-1:0]   eng_left_q;
    logic [READ_LATENCY:0] pipe_valid_q;
    logic [DATA_W-1:0]   pipe_data_q [READ_LATENCY+1];

    logic              q_full, q_empty, q_push, q_pop;
    rd_cmd_t           q_in, q_out;
    logic              acc_rd, acc_wr, size_zero, err_evt, mem_we, issue;
    logic [SIZE_W-1:0] eff_size;
    idx_t              mem_widx, issue_idx;
    logic              unused_cmd_bits;

    assign avl_ready = ~q_full & ~(STALL_EN & lfsr_q[0]);
    assign acc_rd    = reset_n & avl_ready & avl_read_req;
    assign acc_wr    = reset_n & avl_ready & avl_write_req;
    assign size_zero = (avl_size == '0);
    assign eff_size  = size_zero ? SIZE_W'(1) : avl_size;
    assign q_in      = '{addr: CMD_ADDR_W'(avl_addr), size: CMD_SIZE_W'(eff_size)};

    // One error event per cycle at most; reads without burstbegin are also dropped.
    always_comb begin
        q_push   = 1'b0;
        mem_we   = 1'b0;
        err_evt  = 1'b0;
        mem_widx = avl_addr[MEM_AW-1:0];
        unique case (wr_state_q)
            WrIdle: begin
                if (acc_wr) begin
                    err_evt = acc_rd | ~avl_burstbegin | size_zero;
                    mem_we  = avl_burstbegin;
                end else if (acc_rd) begin
                    err_evt = ~avl_burstbegin | size_zero;
                    q_push  = avl_burstbegin;
                end
            end
            WrBurst: begin
                err_evt  = acc_rd | (acc_wr & avl_burstbegin);
                mem_we   = acc_wr & ~avl_burstbegin & ~acc_rd;
                mem_widx = wr_base_q + idx_t'(wr_beat_q);
            end
        endcase
    end

    assign q_pop     = (eng_left_q == '0) & ~q_empty;
    assign issue     = (eng_left_q != '0) | ~q_empty;
    assign issue_idx = q_pop ? idx_t'(q_out.addr) : eng_addr_q;

    assign unused_cmd_bits = ^q_out;

    ddr3_sim_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (q_push),
        .push_cmd (q_in),
        .pop      (q_pop),
        .pop_cmd  (q_out),
        .full     (q_full),
        .empty    (q_empty)
    );

    // Backing store keeps its contents through reset.
    always_ff @(posedge clk) begin
        if (dbg_wr_en && !(mem_we && mem_widx == dbg_addr)) begin
            mem[dbg_addr] <= dbg_wdata;
        end
        if (mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (avl_be[i]) begin
                    mem[mem_widx][8*i +: 8] <= avl_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_q       <= LFSR_SEED;
            err_q        <= '0;
            wr_state_q   <= WrIdle;
            wr_base_q    <= '0;
            wr_size_q    <= '0;
            wr_beat_q    <= '0;
            eng_addr_q   <= '0;
            eng_left_q   <= '0;
            pipe_valid_q <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
            if (err_evt && err_q != 8'hFF) begin
                err_q <= err_q + 8'd1;
            end

            unique case (wr_state_q)
                WrIdle: begin
                    if (mem_we && eff_size > SIZE_W'(1)) begin
                        wr_state_q <= WrBurst;
                        wr_base_q  <= mem_widx;
                        wr_size_q  <= eff_size;
                        wr_beat_q  <= SIZE_W'(1);
                    end
                end
                WrBurst: begin
                    if (mem_we) begin
                        wr_beat_q <= wr_beat_q + SIZE_W'(1);
                        if (wr_beat_q == wr_size_q - SIZE_W'(1)) begin
                            wr_state_q <= WrIdle;
                        end
                    end
                end
            endcase

            if (q_pop) begin
                eng_addr_q <= issue_idx + idx_t'(1);
                eng_left_q <= SIZE_W'(q_out.size) - SIZE_W'(1);
            end else if (eng_left_q != '0) begin
                eng_addr_q <= eng_addr_q + idx_t'(1);
                eng_left_q <= eng_left_q - SIZE_W'(1);
            end

            // Memory is sampled at issue, so a same-edge write is not seen.
            pipe_valid_q   <= {pipe_valid_q[READ_LATENCY-1:0], issue};
            pipe_data_q[0] <= issue ? mem[issue_idx] : '0;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                pipe_data_q[i] <= pipe_data_q[i-1];
            end
        end
    end

    assign avl_rdata_valid = pipe_valid_q[READ_LATENCY];
    assign avl_rdata       = pipe_data_q[READ_LATENCY];
    assign err_count       = err_q;

endmodule

// File: tb/tb_ddr3_avl_mem_model.sv
// Directed and randomized checks of ddr3_avl_mem_model against an array-based memory model.
module tb_ddr3_avl_mem_model;

    localparam int unsigned DW    = 128;
    localparam int unsigned AW    = 26;
    localparam int unsigned SW    = 3;
    localparam int unsigned MAW   = 10;
    localparam int unsigned RL    = 4;
    localparam int unsigned WORDS = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic            rst_n    [2];
    logic            ready    [2];
    logic            bb       [2];
    logic [AW-1:0]   addr     [2];
    logic [SW-1:0]   size     [2];
    logic            rd       [2];
    logic            wr       [2];
    logic [DW-1:0]   wdata    [2];
    logic [DW/8-1:0] be       [2];
    logic            rvalid   [2];
    logic [DW-1:0]   rdata    [2];
    logic            dbg_en   [2];
    logic [MAW-1:0]  dbg_addr [2];
    logic [DW-1:0]   dbg_data [2];
    logic [7:0]      err      [2];

    ddr3_avl_mem_model #(.STALL_EN(1'b0)) u_plain (
        .clk(clk), .reset_n(rst_n[0]), .avl_ready(ready[0]), .avl_burstbegin(bb[0]),
        .avl_addr(addr[0]), .avl_size(size[0]), .avl_read_req(rd[0]), .avl_write_req(wr[0]),
        .avl_wdata(wdata[0]), .avl_be(be[0]), .avl_rdata_valid(rvalid[0]), .avl_rdata(rdata[0]),
        .dbg_wr_en(dbg_en[0]), .dbg_addr(dbg_addr[0]), .dbg_wdata(dbg_data[0]),
        .err_count(err[0])
    );

    ddr3_avl_mem_model #(.STALL_EN(1'b1)) u_stall (
        .clk(clk), .reset_n(rst_n[1]), .avl_ready(ready[1]), .avl_burstbegin(bb[1]),
        .avl_addr(addr[1]), .avl_size(size[1]), .avl_read_req(rd[1]), .avl_write_req(wr[1]),
        .avl_wdata(wdata[1]), .avl_be(be[1]), .avl_rdata_valid(rvalid[1]), .avl_rdata(rdata[1]),
        .dbg_wr_en(dbg_en[1]), .dbg_addr(dbg_addr[1]), .dbg_wdata(dbg_data[1]),
        .err_count(err[1])
    );

    typedef struct {
        longint          c;
        logic [DW-1:0]   data;
    } beat_t;

    beat_t         beats [$];
    logic [DW-1:0] model [2][WORDS];
    int            n_assert = 0;
    int            n_fail   = 0;

    // Only one instance carries read traffic at a time, so one capture queue suffices.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rvalid[d] === 1'b1) beats.push_back('{cyc, rdata[d]});
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ramp(input int i);
        logic [DW-1:0] w;
        for (int j = 0; j < DW/8; j++) w[8*j +: 8] = 8'((16*i + j) % 256);
        return w;
    endfunction

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input int d, input bit is_rd, input bit first, input logic [AW-1:0] a,
                        input logic [SW-1:0] s, input logic [DW-1:0] wd,
                        input logic [DW/8-1:0] bm, output longint t_acc);
        int waited = 0;
        rd[d] = is_rd; wr[d] = !is_rd; bb[d] = first;
        addr[d] = a; size[d] = s; wdata[d] = wd; be[d] = bm;
        while (ready[d] !== 1'b1 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 200) check("ready_timeout", DW'(ready[d]), DW'(1));
        @(posedge clk); #1;
        t_acc = cyc;
        rd[d] = 1'b0; wr[d] = 1'b0; bb[d] = 1'b0;
    endtask

    task automatic write_burst(input int d, input logic [AW-1:0] a, input logic [SW-1:0] s,
                               input logic [DW/8-1:0] bm, input bit rand_data,
                               input logic [DW-1:0] fill);
        longint t;
        int n = (s == 0) ? 1 : int'(s);
        for (int k = 0; k < n; k++) begin
            logic [DW-1:0] wd = rand_data ? rnd128() : fill;
            int idx = (int'(a[MAW-1:0]) + k) % WORDS;
            send(d, 1'b0, k == 0, a, s, wd, bm, t);
            for (int i = 0; i < DW/8; i++) if (bm[i]) model[d][idx][8*i +: 8] = wd[8*i +: 8];
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        int w = 0;
        while (beats.size() < n && w < budget) begin
            @(posedge clk); #1;
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic read_burst(input int d, input logic [AW-1:0] a, input logic [SW-1:0] s,
                              input bit chk_lat);
        longint t;
        int n = (s == 0) ? 1 : int'(s);
        beats.delete();
        send(d, 1'b1, 1'b1, a, s, '0, '0, t);
        wait_beats(n, n + RL + 40);
        check("read_beat_count", DW'(beats.size()), DW'(n));
        for (int k = 0; k < n && k < beats.size(); k++) begin
            check("read_data", beats[k].data, model[d][(int'(a[MAW-1:0]) + k) % WORDS]);
            if (chk_lat) check("read_cycle", DW'(beats[k].c), DW'(t + 1 + RL + k));
        end
    endtask

    initial begin
        longint        t;
        longint        t5 [5];
        int            cnt;
        int            w;
        int            n0;
        logic [DW-1:0] exp_w;

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0; bb[d] = 1'b0;
            addr[d] = '0; size[d] = '0; wdata[d] = '0; be[d] = '0;
            dbg_en[d] = 1'b0; dbg_addr[d] = '0; dbg_data[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_rvalid", DW'(rvalid[0]), DW'(0));
        check("reset_rdata", rdata[0], '0);
        check("reset_err", DW'(err[0]), DW'(0));
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        #1;
        check("ready_after_reset", DW'(ready[0]), DW'(1));

        for (int i = 0; i < WORDS; i++) begin
            for (int d = 0; d < 2; d++) begin
                dbg_en[d] = 1'b1; dbg_addr[d] = MAW'(i); dbg_data[d] = ramp(i);
                model[d][i] = ramp(i);
            end
            @(posedge clk); #1;
        end
        dbg_en[0] = 1'b0; dbg_en[1] = 1'b0;

        // Single-beat read: valid READ_LATENCY+1 cycles after acceptance.
        read_burst(0, 26'd5, 3'd1, 1'b1);
        if (beats.size() > 0) check("ramp_word5", beats[0].data, 128'h5F5E5D5C5B5A59585756555453525150);

        // Byte-enabled burst write that wraps past the top of memory.
        write_burst(0, 26'h3FE, 3'd4, 16'h00FF, 1'b0, '1);
        read_burst(0, 26'h3FE, 3'd4, 1'b1);
        exp_w = ramp(0);
        exp_w[63:0] = '1;
        if (beats.size() > 2) check("wrap_word0", beats[2].data, exp_w);

        // Five back-to-back size-7 reads fill the four-entry queue.
        beats.delete();
        for (int j = 0; j < 5; j++) begin
            send(0, 1'b1, 1'b1, AW'(10 * (j + 1)), 3'd7, '0, '0, t5[j]);
            if (j == 3) check("ready_before_full", DW'(ready[0]), DW'(1));
        end
        check("ready_when_full", DW'(ready[0]), DW'(0));
        wait_beats(35, 120);
        check("stream_beat_count", DW'(beats.size()), DW'(35));
        for (int k = 0; k < 35 && k < beats.size(); k++) begin
            check("stream_data", beats[k].data, model[0][10 * (k / 7 + 1) + k % 7]);
            check("stream_cycle", DW'(beats[k].c), DW'(t5[0] + 1 + RL + k));
        end

        // Protocol errors: size 0, read inside a burst, write without burstbegin.
        check("err_before", DW'(err[0]), DW'(0));
        write_burst(0, 26'd100, 3'd0, '1, 1'b1, '0);
        check("err_size0", DW'(err[0]), DW'(1));
        beats.delete();
        send(0, 1'b0, 1'b1, 26'd200, 3'd2, rnd128(), '0, t);
        send(0, 1'b1, 1'b1, 26'd300, 3'd1, '0, '0, t);
        check("err_read_in_burst", DW'(err[0]), DW'(2));
        send(0, 1'b0, 1'b0, 26'd200, 3'd2, rnd128(), '0, t);
        send(0, 1'b0, 1'b0, 26'd400, 3'd1, rnd128(), '1, t);
        repeat (RL + 6) @(posedge clk);
        #1;
        check("ignored_read_no_beats", DW'(beats.size()), DW'(0));
        check("err_total", DW'(err[0]), DW'(3));
        read_burst(0, 26'd100, 3'd1, 1'b1);
        read_burst(0, 26'd200, 3'd2, 1'b1);
        read_burst(0, 26'd300, 3'd1, 1'b1);
        read_burst(0, 26'd400, 3'd1, 1'b1);

        // Reset mid-burst drops every in-flight beat but keeps memory.
        beats.delete();
        send(0, 1'b1, 1'b1, 26'd500, 3'd7, '0, '0, t);
        w = 0;
        while (beats.size() == 0 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("first_beat_before_reset", DW'(beats.size() > 0), DW'(1));
        rst_n[0] = 1'b0;
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        n0 = beats.size();
        repeat (20) @(posedge clk);
        #1;
        check("no_beats_after_reset", DW'(beats.size()), DW'(n0));
        check("err_cleared", DW'(err[0]), DW'(0));
        check("rdata_cleared", rdata[0], '0);
        read_burst(0, 26'd5, 3'd1, 1'b1);
        read_burst(0, 26'd500, 3'd7, 1'b1);

        // Stalling instance: ready duty cycle with no traffic, then random traffic.
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (ready[1] === 1'b1) cnt++;
        end
        check("ready_duty_in_range", DW'(cnt >= 400 && cnt <= 600), DW'(1));
        for (int op = 0; op < 200; op++) begin
            logic [AW-1:0] a = AW'($urandom);
            logic [SW-1:0] s = SW'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) write_burst(1, a, s, (DW/8)'($urandom), 1'b1, '0);
            else read_burst(1, a, s, 1'b0);
        end
        check("stall_err_zero", DW'(err[1]), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
